// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared widths, sweep-mode encodings and sweep FSM states for
//               the DDS sweep NCO.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    localparam int ACC_W_DEFAULT   = 32;
    localparam int FTW_W_DEFAULT   = 32;
    localparam int DWELL_W_DEFAULT = 16;

    localparam logic [1:0] MODE_FIXED  = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_REPEAT = 2'b10;
    localparam logic [1:0] MODE_UPDOWN = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Sweep FSM stepping the tuning word between start and stop
//               with a programmable dwell per step.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FTW_W   = FTW_W_DEFAULT,
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               i_en,
    input  logic               i_load,
    input  logic               i_start,
    input  logic [1:0]         i_sweep_mode,
    input  logic [FTW_W-1:0]   i_ftw_start,
    input  logic [FTW_W-1:0]   i_ftw_stop,
    input  logic [FTW_W-1:0]   i_ftw_step,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [FTW_W-1:0]   o_ftw_cur,
    output logic               o_busy,
    output logic               o_sweep_done
);

    sweep_state_t        r_state, w_state_nxt;
    logic [DWELL_W-1:0]  r_cnt, w_cnt_nxt;
    logic [FTW_W-1:0]    r_ftw, w_ftw_nxt;
    logic                r_done, w_done_nxt;
    logic [FTW_W:0]      w_up_sum;
    logic signed [FTW_W:0] w_dn_diff;

    // One extra bit so neither direction can wrap past the sweep bounds.
    assign w_up_sum  = {1'b0, r_ftw} + {1'b0, i_ftw_step};
    assign w_dn_diff = $signed({1'b0, r_ftw}) - $signed({1'b0, i_ftw_step});

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ftw   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ftw   <= w_ftw_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ftw_nxt   = r_ftw;
        w_done_nxt  = 1'b0;
        if (i_load) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_ftw_nxt   = i_ftw_start;
        end else if (i_en) begin
            if (i_start) begin
                w_ftw_nxt   = i_ftw_start;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
                if (i_sweep_mode != MODE_FIXED) begin
                    if (i_ftw_start > i_ftw_stop) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = UP;
                    end
                end
            end else if (r_state != IDLE) begin
                if (r_cnt == i_dwell) begin
                    w_cnt_nxt = '0;
                    if (r_state == UP) begin
                        // Repeat mode dwells one step at stop before restarting.
                        if (i_sweep_mode == MODE_REPEAT && r_ftw == i_ftw_stop) begin
                            w_ftw_nxt = i_ftw_start;
                        end else if (w_up_sum >= {1'b0, i_ftw_stop}) begin
                            w_ftw_nxt = i_ftw_stop;
                            case (i_sweep_mode)
                                MODE_SINGLE: begin
                                    w_state_nxt = IDLE;
                                    w_done_nxt  = 1'b1;
                                end
                                MODE_UPDOWN: w_state_nxt = DOWN;
                                default:     w_state_nxt = UP;
                            endcase
                        end else begin
                            w_ftw_nxt = w_up_sum[FTW_W-1:0];
                        end
                    end else begin
                        if (w_dn_diff <= $signed({1'b0, i_ftw_start})) begin
                            w_ftw_nxt   = i_ftw_start;
                            w_state_nxt = UP;
                        end else begin
                            w_ftw_nxt = w_dn_diff[FTW_W-1:0];
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DWELL_W'(1);
                end
            end
        end
    end

    assign o_ftw_cur    = r_ftw;
    assign o_busy       = (r_state != IDLE);
    assign o_sweep_done = r_done;

endmodule
`default_nettype wire

// File: rtl/dds_sweep_nco.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_nco
// Description : Phase-accumulator NCO with offset output and optional linear
//               frequency sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_nco
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int FTW_W   = FTW_W_DEFAULT,
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               en,
    input  logic               load,
    input  logic               start,
    input  logic [1:0]         sweep_mode,
    input  logic [FTW_W-1:0]   ftw_start,
    input  logic [FTW_W-1:0]   ftw_stop,
    input  logic [FTW_W-1:0]   ftw_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ACC_W-1:0]   phase_ofs,
    output logic [ACC_W-1:0]   DDS,
    output logic               wrap,
    output logic [FTW_W-1:0]   ftw_out,
    output logic               busy,
    output logic               sweep_done
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_dds;
    logic             r_wrap;
    logic [FTW_W-1:0] w_ftw_cur;
    logic [ACC_W:0]   w_sum;

    dds_sweep_ctrl #(
        .FTW_W   (FTW_W),
        .DWELL_W (DWELL_W)
    ) u_ctrl (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_en         (en),
        .i_load       (load),
        .i_start      (start),
        .i_sweep_mode (sweep_mode),
        .i_ftw_start  (ftw_start),
        .i_ftw_stop   (ftw_stop),
        .i_ftw_step   (ftw_step),
        .i_dwell      (dwell),
        .o_ftw_cur    (w_ftw_cur),
        .o_busy       (busy),
        .o_sweep_done (sweep_done)
    );

    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(w_ftw_cur);

    // phase_ofs only shapes the output; the accumulator never sees it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_acc  <= '0;
            r_dds  <= '0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_acc  <= '0;
            r_dds  <= phase_ofs;
            r_wrap <= 1'b0;
        end else if (en) begin
            r_acc  <= w_sum[ACC_W-1:0];
            r_dds  <= w_sum[ACC_W-1:0] + phase_ofs;
            r_wrap <= w_sum[ACC_W];
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign DDS     = r_dds;
    assign wrap    = r_wrap;
    assign ftw_out = w_ftw_cur;

endmodule
`default_nettype wire
